dpe_table_arbiter: RTL and testbench

Round-robin arbiter sharing the single read port (port B) of a DPE lookup table RAM (routing table or cryptokey table) among up to N lookup clients inside the Data Plane Engine. Clients issue word-read beats, optionally grouped into locked multi-word bursts; the arbiter drives the RAM address, tracks the RAM read latency, and routes each returned word to its owner. It sits between the egress/ingress lookup stages and the `tdp_ram` instance, while port A stays with the CSR bus.

---
 rtl/dpe_pkg.sv | 11 +
 rtl/dpe_rr_picker.sv | 31 +++
 rtl/dpe_table_arbiter.sv | 119 +++++++++++
 tb/tb_dpe_table_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpe_pkg.sv
// Shared types and constants for the DPE table-port arbiter.
package dpe_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } dpe_arb_state_t;

  localparam int unsigned DPE_ARB_CNT_W = 16;

endpackage

// File: rtl/dpe_rr_picker.sv
// Rotate-priority encoder: first set request at or above ptr, wrapping to 0.
module dpe_rr_picker #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx
);

  int unsigned j;
  logic        found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      j = 32'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/dpe_table_arbiter.sv
// Round-robin arbiter for the lookup-table RAM read port with locked bursts.
// Optional per-client grant counters are built when DPE_ARB_STATS_EN is defined.
module dpe_table_arbiter
  import dpe_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_REQ-1:0]               req_valid,
  input  logic [N_REQ-1:0]               req_last,
  input  logic [N_REQ*ADDR_WIDTH-1:0]    req_addr,
  output logic [N_REQ-1:0]               req_ready,
  output logic [N_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic [ADDR_WIDTH-1:0]          ram_addr,
  input  logic [DATA_WIDTH-1:0]          ram_dout,
  output logic                           idle,
  output logic [N_REQ*DPE_ARB_CNT_W-1:0] grant_cnt
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  dpe_arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [N_REQ-1:0]      pipe_q [RD_LATENCY];
  logic [N_REQ-1:0]      pick_gnt;
  logic [IDX_W-1:0]      pick_idx, gnt_idx;
  logic                  accept, pipe_busy;

  dpe_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // req_ready is already gated by req_valid, so it doubles as the accepted-beat tag.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    req_ready = '0;
    gnt_idx   = pick_idx;
    if (state_q == IDLE) begin
      req_ready = pick_gnt;
    end else begin
      gnt_idx            = owner_q;
      req_ready[owner_q] = req_valid[owner_q];
    end
    accept = |req_ready;
    if (accept) begin
      if (req_last[gnt_idx]) begin
        rr_ptr_d = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        state_d  = IDLE;
      end else begin
        owner_d = gnt_idx;
        state_d = LOCKED;
      end
    end
    ram_addr = accept ? req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH] : ram_addr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      ram_addr_q <= '0;
      for (int k = 0; k < RD_LATENCY; k++) pipe_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      ram_addr_q <= ram_addr;
      pipe_q[0]  <= req_ready;
      for (int k = 1; k < RD_LATENCY; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int k = 0; k < RD_LATENCY; k++) pipe_busy = pipe_busy | (|pipe_q[k]);
  end

  assign rsp_valid = pipe_q[RD_LATENCY-1];
  assign rsp_data  = (|rsp_valid) ? ram_dout : '0;
  assign idle      = (state_q == IDLE) && !pipe_busy;

`ifdef DPE_ARB_STATS_EN
  logic [DPE_ARB_CNT_W-1:0] cnt_q [N_REQ];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_ready[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < N_REQ; i++) grant_cnt[i*DPE_ARB_CNT_W +: DPE_ARB_CNT_W] = cnt_q[i];
  end
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_dpe_table_arbiter.sv
// Directed bench for dpe_table_arbiter (RD_LATENCY 1 and 3 instances).
module tb_dpe_table_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req_valid, req_last, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [DW-1:0]   rsp_data, ram_dout;
  logic [AW-1:0]   ram_addr;
  logic            idle;
  logic [N*16-1:0] grant_cnt;

  logic            rst3;
  logic [N-1:0]    rv3, rl3, rr3, rspv3;
  logic [N*AW-1:0] ra3;
  logic [DW-1:0]   rspd3, rdout3, r3_s1, r3_s2;
  logic [AW-1:0]   raddr3;
  logic            idle3;
  logic [N*16-1:0] gcnt3;

  int n_cmp = 0;
  int n_err = 0;

  dpe_table_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .idle(idle), .grant_cnt(grant_cnt)
  );

  dpe_table_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst3), .req_valid(rv3), .req_last(rl3), .req_addr(ra3),
    .req_ready(rr3), .rsp_valid(rspv3), .rsp_data(rspd3), .ram_addr(raddr3),
    .ram_dout(rdout3), .idle(idle3), .grant_cnt(gcnt3)
  );

  function automatic logic [31:0] ramval(input logic [7:0] a);
    return (a == 8'h05) ? 32'hDEADBEEF : {24'hC0DE00, a};
  endfunction

  // RAM models: latency 1 and latency 3
  always @(posedge clk) ram_dout <= ramval(ram_addr);
  always @(posedge clk) begin
    r3_s1  <= ramval(raddr3);
    r3_s2  <= r3_s1;
    rdout3 <= r3_s2;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    req_valid = '0;
    req_last  = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
    n_cmp++; if (rsp_data !== 32'h0) begin n_err++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    n_cmp++; if (ram_addr !== 8'h00) begin n_err++; $display("FAIL reset_ram_addr: got %h want 00", ram_addr); end
    n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL reset_idle: got %b want 1", idle); end
    n_cmp++; if (grant_cnt !== 64'h0) begin n_err++; $display("FAIL reset_grant_cnt: got %h want 0", grant_cnt); end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0001;
    req_last  = 4'b1111;
    req_addr[0 +: AW] = 8'h05;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    n_cmp++; if (ram_addr !== 8'h05) begin n_err++; $display("FAIL single_ram_addr: got %h want 05", ram_addr); end
    tick();
    req_valid = '0;
    #1;
    n_cmp++; if (rsp_valid !== 4'b0001) begin n_err++; $display("FAIL single_rsp_valid: got %b want 0001", rsp_valid); end
    n_cmp++; if (rsp_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_rsp_data: got %h want deadbeef", rsp_data); end
    n_cmp++; if (ram_addr !== 8'h05) begin n_err++; $display("FAIL single_addr_hold: got %h want 05", ram_addr); end
    tick();
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL single_rsp_done: got %b want 0000", rsp_valid); end
  endtask

  task automatic test_fairness();
    logic [3:0]  exp;
    logic [7:0]  a;
    logic [15:0] exp_cnt;
`ifdef DPE_ARB_STATS_EN
    exp_cnt = 16'd2;
`else
    exp_cnt = 16'd0;
`endif
    do_reset();
    for (int k = 0; k < N; k++) req_addr[k*AW +: AW] = 8'(32'h10 + k);
    req_last  = 4'b1111;
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      exp = 4'(1 << (i % 4));
      n_cmp++; if (req_ready !== exp) begin n_err++; $display("FAIL fair_grant%0d: got %b want %b", i, req_ready, exp); end
      if (i > 0) begin
        exp = 4'(1 << ((i - 1) % 4));
        a   = 8'(32'h10 + (i - 1) % 4);
        n_cmp++; if (rsp_valid !== exp) begin n_err++; $display("FAIL fair_rsp%0d: got %b want %b", i, rsp_valid, exp); end
        n_cmp++; if (rsp_data !== ramval(a)) begin n_err++; $display("FAIL fair_data%0d: got %h want %h", i, rsp_data, ramval(a)); end
      end
      tick();
    end
    req_valid = '0;
    #1;
    n_cmp++; if (rsp_valid !== 4'b1000) begin n_err++; $display("FAIL fair_rsp_last: got %b want 1000", rsp_valid); end
    tick();
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (grant_cnt[k*16 +: 16] !== exp_cnt) begin
        n_err++; $display("FAIL fair_cnt%0d: got %0d want %0d", k, grant_cnt[k*16 +: 16], exp_cnt);
      end
    end
  endtask

  task automatic test_lock();
    logic [7:0] a;
    do_reset();
    // Client 1 single read first so rr_ptr lands on 2.
    req_valid = 4'b0010;
    req_last  = 4'b1111;
    req_addr[1*AW +: AW] = 8'h11;
    tick();
    for (int b = 0; b < 4; b++) begin
      req_valid = 4'b0110;
      req_last  = {1'b0, (b == 3), 1'b1, 1'b0};
      a = 8'(32'h20 + b);
      req_addr[2*AW +: AW] = a;
      #1;
      n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL lock_grant%0d: got %b want 0100", b, req_ready); end
      n_cmp++; if (ram_addr !== a) begin n_err++; $display("FAIL lock_addr%0d: got %h want %h", b, ram_addr, a); end
      if (b > 0) begin
        n_cmp++; if (rsp_data !== ramval(a - 8'd1)) begin n_err++; $display("FAIL lock_data%0d: got %h want %h", b, rsp_data, ramval(a - 8'd1)); end
      end
      if (b == 2) begin
        n_cmp++; if (idle !== 1'b0) begin n_err++; $display("FAIL lock_idle: got %b want 0", idle); end
      end
      tick();
    end
    req_valid = 4'b0010;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL lock_release: got %b want 0010", req_ready); end
    n_cmp++; if (rsp_valid !== 4'b0100) begin n_err++; $display("FAIL lock_last_rsp: got %b want 0100", rsp_valid); end
    tick();
    req_valid = '0;
    tick();
  endtask

  task automatic test_ptr_wrap();
    do_reset();
    req_last  = 4'b1111;
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b1011;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL wrap_ptr3: got %b want 1000", req_ready); end
    tick();
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL wrap_ptr0: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    tick();
  endtask

  task automatic test_owner_stall();
    do_reset();
    req_valid = 4'b0100;
    req_last  = 4'b0000;
    req_addr[2*AW +: AW] = 8'h30;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL stall_start: got %b want 0100", req_ready); end
    tick();
    req_valid = 4'b0011;
    req_last  = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL stall_block%0d: got %b want 0000", i, req_ready); end
      n_cmp++; if (idle !== 1'b0) begin n_err++; $display("FAIL stall_idle%0d: got %b want 0", i, idle); end
      n_cmp++; if (ram_addr !== 8'h30) begin n_err++; $display("FAIL stall_addr%0d: got %h want 30", i, ram_addr); end
      tick();
    end
    req_valid = 4'b0111;
    req_addr[2*AW +: AW] = 8'h31;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL stall_resume: got %b want 0100", req_ready); end
    tick();
    req_valid = 4'b0011;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL stall_after: got %b want 0001", req_ready); end
    n_cmp++; if (rsp_data !== ramval(8'h31)) begin n_err++; $display("FAIL stall_data: got %h want %h", rsp_data, ramval(8'h31)); end
    tick();
    req_valid = '0;
    tick();
    n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL stall_drain_idle: got %b want 1", idle); end
  endtask

  task automatic test_reset_midflight();
    rst3 = 1'b1;
    rl3  = 4'b1111;
    rv3  = 4'b0001;
    ra3[0 +: AW] = 8'h40;
    tick();
    rv3 = 4'b0010;
    ra3[1*AW +: AW] = 8'h41;
    #1;
    n_cmp++; if (rr3 !== 4'b0010) begin n_err++; $display("FAIL mid_second_beat: got %b want 0010", rr3); end
    tick();
    rv3  = '0;
    rst3 = 1'b0;
    tick();
    rst3 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (rspv3 !== 4'b0000) begin n_err++; $display("FAIL mid_rsp%0d: got %b want 0000", i, rspv3); end
      n_cmp++; if (idle3 !== 1'b1) begin n_err++; $display("FAIL mid_idle%0d: got %b want 1", i, idle3); end
      tick();
    end
    rv3 = 4'b0100;
    ra3[2*AW +: AW] = 8'h42;
    #1;
    n_cmp++; if (rr3 !== 4'b0100) begin n_err++; $display("FAIL lat3_grant: got %b want 0100", rr3); end
    tick();
    rv3 = '0;
    tick();
    n_cmp++; if (rspv3 !== 4'b0000) begin n_err++; $display("FAIL lat3_early: got %b want 0000", rspv3); end
    tick();
    n_cmp++; if (rspv3 !== 4'b0100) begin n_err++; $display("FAIL lat3_rsp: got %b want 0100", rspv3); end
    n_cmp++; if (rspd3 !== ramval(8'h42)) begin n_err++; $display("FAIL lat3_data: got %h want %h", rspd3, ramval(8'h42)); end
  endtask

`ifdef DPE_ARB_STATS_EN
  task automatic test_saturation();
    do_reset();
    req_valid = 4'b0001;
    req_last  = 4'b1111;
    repeat (70000) tick();
    req_valid = '0;
    tick();
    n_cmp++; if (grant_cnt[15:0] !== 16'hFFFF) begin n_err++; $display("FAIL sat_cnt0: got %h want ffff", grant_cnt[15:0]); end
    n_cmp++; if (grant_cnt[63:16] !== 48'h0) begin n_err++; $display("FAIL sat_others: got %h want 0", grant_cnt[63:16]); end
  endtask
`endif

  initial begin
    rst       = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_addr  = '0;
    rst3      = 1'b0;
    rv3       = '0;
    rl3       = '0;
    ra3       = '0;
    test_reset();
    test_single();
    test_fairness();
    test_lock();
    test_ptr_wrap();
    test_owner_stall();
    test_reset_midflight();
`ifdef DPE_ARB_STATS_EN
    test_saturation();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
